// File: rtl/alu_matrix_pkg.sv
// alu_matrix_pkg: shared constants, sel codes and matrix type for the 3x3 matrix ALU
package alu_matrix_pkg;
    localparam int WIDTH = 32;
    localparam int N = 3;
    localparam logic [5:0] SEL_A_BASE = 6'd0;
    localparam logic [5:0] SEL_B_BASE = 6'd9;
    localparam logic [5:0] SEL_R_BASE = 6'd18;
    localparam logic [5:0] OP_MUL = 6'd27;
    localparam logic [5:0] OP_TRANS = 6'd28;
    localparam logic [5:0] OP_ADD = 6'd29;
    typedef logic [N*N-1:0][WIDTH-1:0] mat_t;
    typedef enum logic [1:0] {ALU_MUL, ALU_TRANS, ALU_ADD} alu_op_t;
endpackage

// File: rtl/matrix_alu_core.sv
// matrix_alu_core: combinational next-R for multiply, transpose and add
// ports: a, b operand matrices (row-major); op selects the result; r is the next R
module matrix_alu_core
    import alu_matrix_pkg::*;
(
    input  mat_t    a,
    input  mat_t    b,
    input  alu_op_t op,
    output mat_t    r
);
    mat_t prod, trans, sum;
    always_comb begin
        prod = '0;
        trans = '0;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < N; k++)
                    prod[i*N+j] = prod[i*N+j] + a[i*N+k] * b[k*N+j];
                trans[i*N+j] = a[j*N+i];
                sum[i*N+j] = a[i*N+j] + b[i*N+j];
            end
        end
        r = op == ALU_MUL ? prod : op == ALU_TRANS ? trans : sum;
    end
endmodule

// File: rtl/alu_matrix_top.sv
// alu_matrix_top: 3x3 matrix ALU behind a single sel-coded register interface
// ports: clk, reset (async, active-high), sel command/address, eleIn write data,
//        eleOut combinational read of R[sel-18] (0 outside 18..26)
module alu_matrix_top
    import alu_matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       sel,
    input  logic [WIDTH-1:0] eleIn,
    output logic [WIDTH-1:0] eleOut
);
    mat_t a, b, r, r_next;
    alu_op_t op;
    logic [3:0] ai, bi, ri;
    logic is_a, is_b, is_rd, is_op;
    assign ai = 4'(sel - SEL_A_BASE);
    assign bi = 4'(sel - SEL_B_BASE);
    assign ri = 4'(sel - SEL_R_BASE);
    assign is_a = sel < SEL_B_BASE;
    assign is_b = sel >= SEL_B_BASE && sel < SEL_R_BASE;
    assign is_rd = sel >= SEL_R_BASE && sel < OP_MUL;
    assign is_op = sel >= OP_MUL && sel <= OP_ADD;
    assign op = sel == OP_MUL ? ALU_MUL : sel == OP_TRANS ? ALU_TRANS : ALU_ADD;
    matrix_alu_core u_core (.a(a), .b(b), .op(op), .r(r_next));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a <= '0;
            b <= '0;
            r <= '0;
        end else begin
            if (is_a) a[ai] <= eleIn;
            if (is_b) b[bi] <= eleIn;
            if (is_op) r <= r_next;
        end
    end
    assign eleOut = is_rd ? r[ri] : '0;
endmodule

// File: tb/tb_alu_matrix_top.sv
// tb_alu_matrix_top: directed vectors against a behavioural matrix model plus literal checks
module tb_alu_matrix_top;
    logic clk = 0;
    logic reset = 1;
    logic [5:0] sel = 0;
    logic [31:0] eleIn = 0;
    logic [31:0] eleOut;
    logic [31:0] ma[9], mb[9], mr[9];
    int total = 0;
    int bad = 0;
    logic [31:0] tr_exp[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    logic [31:0] add_exp[9] = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
    logic [31:0] mul_exp[9] = '{15, 18, 21, 42, 54, 66, 69, 90, 111};

    alu_matrix_top dut (.clk(clk), .reset(reset), .sel(sel), .eleIn(eleIn), .eleOut(eleOut));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 9; k++) begin
            ma[k] = 0;
            mb[k] = 0;
            mr[k] = 0;
        end
    endtask

    task automatic model_apply(input int s, input logic [31:0] d);
        logic [31:0] t[9];
        if (s < 9) ma[s] = d;
        else if (s < 18) mb[s-9] = d;
        else if (s >= 27 && s <= 29) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    logic [31:0] acc;
                    acc = 0;
                    for (int k = 0; k < 3; k++) acc += ma[i*3+k] * mb[k*3+j];
                    t[i*3+j] = s == 27 ? acc : s == 28 ? ma[j*3+i] : ma[i*3+j] + mb[i*3+j];
                end
            mr = t;
        end
    endtask

    function automatic logic [31:0] model_out(input int s);
        return (s >= 18 && s <= 26) ? mr[s-18] : 32'd0;
    endfunction

    task automatic step(input int s, input logic [31:0] d);
        sel = 6'(s);
        eleIn = d;
        @(posedge clk);
        if (!reset) model_apply(s, d);
        #1;
    endtask

    task automatic rd(input string nm, input int k, input logic [31:0] exp);
        sel = 6'(18 + k);
        #1;
        chk(nm, eleOut, exp);
        chk({nm, "_model"}, mr[k], exp);
    endtask

    initial begin
        model_clear();
        fork
            forever begin
                @(negedge clk);
                chk("cycle", eleOut, model_out(int'(sel)));
            end
        join_none
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) rd("rst_init", k, 0);
        reset = 0;
        for (int k = 0; k < 9; k++) step(k, 32'(100 + k));
        for (int k = 0; k < 9; k++) step(9 + k, 32'(7 * k + 1));
        step(29, 0);
        rd("pre_rst", 0, 101);
        step(27, 0);
        reset = 1;
        model_clear();
        for (int k = 0; k < 9; k++) rd("rst_high", k, 0);
        step(29, 0);
        reset = 0;
        for (int k = 0; k < 9; k++) rd("rst_after", k, 0);
        for (int k = 0; k < 9; k++) step(k, 32'(k));
        step(28, 0);
        for (int k = 0; k < 9; k++) rd("trans", k, tr_exp[k]);
        for (int k = 0; k < 9; k++) step(9 + k, 32'(k));
        step(29, 0);
        for (int k = 0; k < 9; k++) rd("add", k, add_exp[k]);
        step(27, 0);
        step(27, 0);
        for (int k = 0; k < 9; k++) rd("mul", k, mul_exp[k]);
        step(28, 0);
        for (int k = 0; k < 9; k++) rd("trans_again", k, tr_exp[k]);
        step(45, 32'hDEAD_BEEF);
        chk("noop_out", eleOut, 0);
        step(63, 32'h1234_5678);
        for (int k = 0; k < 9; k++) rd("noop_hold", k, tr_exp[k]);
        for (int k = 1; k < 9; k++) begin
            step(k, 0);
            step(9 + k, 0);
        end
        step(0, 32'hFFFF_FFFF);
        step(9, 32'hFFFF_FFFF);
        step(29, 0);
        rd("wrap_add", 0, 32'hFFFF_FFFE);
        rd("wrap_add_r8", 8, 0);
        step(27, 0);
        rd("wrap_mul", 0, 32'h0000_0001);
        rd("wrap_mul_r4", 4, 0);
        sel = 6'd30;
        #1;
        chk("default_out", eleOut, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
